bbox_tracker: RTL and testbench
===============================

BBOX_TRACKER -- requirements
Module: bbox_tracker

Interface
REQ-001 Parameter NUM_CH, 5, number of colour channels tracked (1..8).
REQ-002 Parameter COORD_W, 11, coordinate width (max 15).
REQ-003 Parameter IMAGE_W, 640, active pixels per line.
REQ-004 Parameter CNT_W, 20, per-channel pixel-count width.
REQ-005 Parameter MSG_INTERVAL, 120, frames between message bursts (>=1).
REQ-006 clk  in  1  clock.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 pix_valid  in  1  pixel beat valid (already handshaken upstream).
REQ-009 pix_sop / pix_eop  in  1 each  packet start / end, qualified by pix_valid.
REQ-010 pix_is_video  in  1  on the SOP beat, 1 = video packet.
REQ-011 det  in  NUM_CH  per-pixel detect flags, aligned with pix_valid.
REQ-012 roi_top  in  COORD_W  first row counted; rows < roi_top ignored.
REQ-013 min_pix  in  CNT_W  minimum count for a channel box to be valid.
REQ-014 bb_left/bb_right/bb_top/bb_bot  out  NUM_CH*COORD_W each  latched boxes, channel i at [i*COORD_W +: COORD_W].
REQ-015 bb_valid  out  NUM_CH  channel box valid for the last accepted frame.
REQ-016 frame_done  out  1  one-cycle pulse when a frame result is latched.
REQ-017 frame_drop  out  1  one-cycle pulse when a frame result is discarded.
REQ-018 msg_data  out  32 / msg_valid out 1 / msg_ready in 1  message stream.

Function
REQ-019 x,y counters SHALL clear on a SOP beat; each non-SOP beat advances x; x == IMAGE_W-1 wraps x to 0 and increments y.
REQ-020 The SOP beat SHALL latch pix_is_video into packet_video and SHALL not be counted as a pixel.
REQ-021 A beat qualifies when pix_valid & ~pix_sop & packet_video & y >= roi_top.
REQ-022 On a qualifying beat, only the lowest-index asserted det bit is updated (priority encoding).
REQ-023 Update: min_x=min(min_x,x), max_x=max(max_x,x), min_y=min(min_y,y), max_y=y, count+1 saturating at 2^CNT_W-1.
REQ-024 On SOP all accumulators SHALL reload: min_x=IMAGE_W-1, max_x=0, min_y=all-ones, max_y=0, count=0; a mid-frame SOP discards the partial frame.
REQ-025 On a qualifying EOP beat (pix_valid & pix_eop & packet_video) with the message FSM IDLE, outputs latch next cycle: bb_left=min_x, bb_right=max_x, bb_top=min_y, bb_bot=max_y, bb_valid[i]=(count_i >= min_pix), frame_done=1, using values including the EOP pixel.
REQ-026 If the FSM is not IDLE at EOP, outputs SHALL hold and frame_drop SHALL pulse; the frame counter is not decremented.
REQ-027 Non-video packets SHALL never update accumulators, outputs or counters.
REQ-028 Frame counter: on each latched frame, if counter == 0, reload MSG_INTERVAL-1 and start FSM; else decrement.
REQ-029 FSM states: IDLE, HDR, TL, BR; HDR -> TL(ch0) -> BR(ch0) -> TL(ch1) ... BR(NUM_CH-1) -> IDLE.
REQ-030 Each state holds msg_valid=1 and advances only on msg_valid & msg_ready; msg_data stable while stalled.
REQ-031 HDR word = {"BB", 8'(NUM_CH), frame_seq[7:0]}; frame_seq increments (mod 256) per burst after HDR is sent.
REQ-032 TL word = {bb_valid[i], zero-extended bb_left to 15 bits, zero-extended bb_top to 16 bits}.
REQ-033 BR word = {1'b0, zero-extended bb_right to 15 bits, zero-extended bb_bot to 16 bits}.
REQ-034 Burst length SHALL be exactly 1+2*NUM_CH words; msg_valid=0 in IDLE.

Reset
REQ-035 When reset_n=0 at a clk edge: bb_* = 0, bb_valid = 0, frame_done = frame_drop = 0, msg_valid = 0, FSM = IDLE, frame counter = 0, frame_seq = 0, packet_video = 0, accumulators at SOP reload values.
REQ-036 Reset mid-burst SHALL abort the burst with msg_valid low the following cycle; no partial word is reissued.

Verification
REQ-037 NUM_CH=5, 640x480 frame, 20 ch0 pixels in rows 300..303, x 100..104, roi_top=240, min_pix=16 -> bb_left0=100, bb_right0=104, bb_top0=300, bb_bot0=303, bb_valid0=1, frame_done pulse.
REQ-038 Same frame but min_pix=21 -> bb_valid0=0, coordinates still latched; channels with no hits report left=639, right=0.
REQ-039 Pixel with det=5'b00110 at (10,400) -> only ch1 updated; ch2 count stays 0.
REQ-040 MSG_INTERVAL=1, msg_ready toggling 50% -> 11 words, HDR=0x42420500 then 0x42420501 next burst; data stable during stalls.
REQ-041 Second EOP while burst stalled (msg_ready=0) -> frame_drop pulse, bb_* unchanged, burst completes after ready.
REQ-042 Non-video packet (pix_is_video=0) full of det hits between frames -> no output change, no frame_done.

Source files
------------

// File: rtl/bbox_tracker_if.sv
// Stream bundle for bbox_tracker: the incoming pixel beats and the outgoing message words.
// Message handshake: a word transfers on a clk edge where msg_valid & msg_ready; once
// msg_valid is high, msg_valid and msg_data hold unchanged until that transfer.
interface bbox_tracker_if #(
  parameter int NUM_CH = 5
);
  logic              pix_valid;
  logic              pix_sop;
  logic              pix_eop;
  logic              pix_is_video;
  logic [NUM_CH-1:0] det;
  logic [31:0]       msg_data;
  logic              msg_valid;
  logic              msg_ready;

  modport master (
    output pix_valid, pix_sop, pix_eop, pix_is_video, det, msg_ready,
    input  msg_data, msg_valid
  );

  modport slave (
    input  pix_valid, pix_sop, pix_eop, pix_is_video, det, msg_ready,
    output msg_data, msg_valid
  );
endinterface

// File: rtl/bbox_tracker.sv
// Per-colour-channel bounding-box tracker over a video packet stream, with a
// periodic message burst reporting the latched boxes.
module bbox_tracker #(
  parameter int NUM_CH       = 5,
  parameter int COORD_W      = 11,
  parameter int IMAGE_W      = 640,
  parameter int CNT_W        = 20,
  parameter int MSG_INTERVAL = 120
) (
  input  logic                      clk,
  input  logic                      reset_n,
  bbox_tracker_if.slave             bus,
  input  logic [COORD_W-1:0]        roi_top,
  input  logic [CNT_W-1:0]          min_pix,
  output logic [NUM_CH*COORD_W-1:0] bb_left,
  output logic [NUM_CH*COORD_W-1:0] bb_right,
  output logic [NUM_CH*COORD_W-1:0] bb_top,
  output logic [NUM_CH*COORD_W-1:0] bb_bot,
  output logic [NUM_CH-1:0]         bb_valid,
  output logic                      frame_done,
  output logic                      frame_drop,
  output logic [1:0]                dbg_state_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FC_W = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMAGE_W - 1);
  localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [FC_W-1:0]    FC_RELOAD = FC_W'(MSG_INTERVAL - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TL, S_BR} state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [FC_W-1:0]           fcnt_q;
  logic [7:0]                seq_q;
  logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
  logic                      video_q, video_d;
  logic [COORD_W-1:0]        min_x_q [NUM_CH];
  logic [COORD_W-1:0]        min_x_d [NUM_CH];
  logic [COORD_W-1:0]        max_x_q [NUM_CH];
  logic [COORD_W-1:0]        max_x_d [NUM_CH];
  logic [COORD_W-1:0]        min_y_q [NUM_CH];
  logic [COORD_W-1:0]        min_y_d [NUM_CH];
  logic [COORD_W-1:0]        max_y_q [NUM_CH];
  logic [COORD_W-1:0]        max_y_d [NUM_CH];
  logic [CNT_W-1:0]          cnt_q [NUM_CH];
  logic [CNT_W-1:0]          cnt_d [NUM_CH];
  logic [NUM_CH*COORD_W-1:0] bb_left_q, bb_right_q, bb_top_q, bb_bot_q;
  logic [NUM_CH-1:0]         bb_valid_q;
  logic                      done_q, drop_q;
  logic                      qualify, eop_hit, latch, drop, hit_done, hs;
  logic                      msg_valid_w;
  logic [31:0]               msg_data_w;

  assign qualify = bus.pix_valid && !bus.pix_sop && video_q && (y_q >= roi_top);
  assign eop_hit = bus.pix_valid && bus.pix_eop && video_q;
  assign latch   = eop_hit && (state_q == S_IDLE);
  assign drop    = eop_hit && (state_q != S_IDLE);
  assign hs      = msg_valid_w && bus.msg_ready;

  // Next accumulator values; the EOP latch uses these so the EOP pixel is included.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    video_d  = video_q;
    hit_done = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      min_x_d[i] = min_x_q[i];
      max_x_d[i] = max_x_q[i];
      min_y_d[i] = min_y_q[i];
      max_y_d[i] = max_y_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    if (bus.pix_valid && bus.pix_sop) begin
      x_d     = '0;
      y_d     = '0;
      video_d = bus.pix_is_video;
      for (int i = 0; i < NUM_CH; i++) begin
        min_x_d[i] = X_LAST;
        max_x_d[i] = '0;
        min_y_d[i] = '1;
        max_y_d[i] = '0;
        cnt_d[i]   = '0;
      end
    end else if (bus.pix_valid && video_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (qualify && bus.det[i] && !hit_done) begin
          hit_done = 1'b1;
          if (x_q < min_x_q[i]) min_x_d[i] = x_q;
          if (x_q > max_x_q[i]) max_x_d[i] = x_q;
          if (y_q < min_y_q[i]) min_y_d[i] = y_q;
          max_y_d[i] = y_q;
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: if (latch && (fcnt_q == '0)) begin
        state_d = S_HDR;
        ch_d    = '0;
      end
      S_HDR: if (hs) state_d = S_TL;
      S_TL:  if (hs) state_d = S_BR;
      S_BR: if (hs) begin
        if (ch_q == CH_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TL;
          ch_d    = ch_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Words come from the latched box registers, which cannot change while a burst runs.
  always_comb begin
    msg_valid_w = (state_q != S_IDLE);
    msg_data_w  = '0;
    case (state_q)
      S_HDR: msg_data_w = {16'h4242, 8'(NUM_CH), seq_q};
      S_TL:  msg_data_w = {bb_valid_q[ch_q], 15'(bb_left_q[ch_q*COORD_W +: COORD_W]),
                           16'(bb_top_q[ch_q*COORD_W +: COORD_W])};
      S_BR:  msg_data_w = {1'b0, 15'(bb_right_q[ch_q*COORD_W +: COORD_W]),
                           16'(bb_bot_q[ch_q*COORD_W +: COORD_W])};
      default: msg_data_w = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      video_q    <= 1'b0;
      fcnt_q     <= '0;
      seq_q      <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      bb_left_q  <= '0;
      bb_right_q <= '0;
      bb_top_q   <= '0;
      bb_bot_q   <= '0;
      bb_valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        min_x_q[i] <= X_LAST;
        max_x_q[i] <= '0;
        min_y_q[i] <= '1;
        max_y_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      video_q <= video_d;
      done_q  <= latch;
      drop_q  <= drop;
      for (int i = 0; i < NUM_CH; i++) begin
        min_x_q[i] <= min_x_d[i];
        max_x_q[i] <= max_x_d[i];
        min_y_q[i] <= min_y_d[i];
        max_y_q[i] <= max_y_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      if (latch) begin
        for (int i = 0; i < NUM_CH; i++) begin
          bb_left_q[i*COORD_W +: COORD_W]  <= min_x_d[i];
          bb_right_q[i*COORD_W +: COORD_W] <= max_x_d[i];
          bb_top_q[i*COORD_W +: COORD_W]   <= min_y_d[i];
          bb_bot_q[i*COORD_W +: COORD_W]   <= max_y_d[i];
          bb_valid_q[i]                    <= (cnt_d[i] >= min_pix);
        end
        fcnt_q <= (fcnt_q == '0) ? FC_RELOAD : fcnt_q - 1'b1;
      end
      if ((state_q == S_HDR) && hs) seq_q <= seq_q + 8'd1;
    end
  end

  assign bus.msg_valid = msg_valid_w;
  assign bus.msg_data  = msg_data_w;
  assign bb_left       = bb_left_q;
  assign bb_right      = bb_right_q;
  assign bb_top        = bb_top_q;
  assign bb_bot        = bb_bot_q;
  assign bb_valid      = bb_valid_q;
  assign frame_done    = done_q;
  assign frame_drop    = drop_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench for bbox_tracker: a hit-list model derives boxes and message bursts per frame,
// and a negedge compare process checks every output each cycle against it.
module tb_bbox_tracker;
  localparam int NCH = 5, CW = 11, IW = 120, CNTW = 20, MI = 2;
  localparam int ROWS = 36, NPIX = IW * ROWS, ROI = 24;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [CW-1:0]       roi_top = CW'(ROI);
  logic [CNTW-1:0]     min_pix = 20'd16;
  logic [NCH*CW-1:0]   bb_left, bb_right, bb_top, bb_bot;
  logic [NCH-1:0]      bb_valid;
  logic                frame_done, frame_drop;
  logic [1:0]          dbg_state;

  bbox_tracker_if #(.NUM_CH(NCH)) bus();

  bbox_tracker #(.NUM_CH(NCH), .COORD_W(CW), .IMAGE_W(IW), .CNT_W(CNTW), .MSG_INTERVAL(MI)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .roi_top(roi_top), .min_pix(min_pix),
    .bb_left(bb_left), .bb_right(bb_right), .bb_top(bb_top), .bb_bot(bb_bot),
    .bb_valid(bb_valid), .frame_done(frame_done), .frame_drop(frame_drop),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int                tests_run = 0, tests_failed = 0;
  logic [31:0]       exp_q[$];
  logic [NCH*CW-1:0] e_left = '0, e_right = '0, e_top = '0, e_bot = '0;
  logic [NCH-1:0]    e_valid = '0;
  bit                exp_done = 0, exp_drop = 0, chk_en = 0;
  int                fcnt = 0, seq = 0, rdy_mode = 0, dones_seen = 0, drops_seen = 0;
  logic [31:0]       last_hdr = '0, last_tl0 = '0;
  int                hx[$], hy[$];
  logic [NCH-1:0]    hd[$];
  bit                prev_stall = 0;
  logic [31:0]       prev_data = '0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add_hit(input int x, input int y, input logic [NCH-1:0] d);
    hx.push_back(x); hy.push_back(y); hd.push_back(d);
  endtask

  task automatic clear_hits();
    hx.delete(); hy.delete(); hd.delete();
  endtask

  function automatic logic [NCH-1:0] det_at(input int x, input int y);
    logic [NCH-1:0] d = '0;
    for (int k = 0; k < hx.size(); k++)
      if (hx[k] == x && hy[k] == y) d |= hd[k];
    return d;
  endfunction

  // Boxes from the hit list: lowest set channel wins, rows above ROI and unsent pixels ignored.
  task automatic model_latch(input int n_pix);
    int ml[NCH], mr[NCH], mt[NCH], mb[NCH], mc[NCH];
    int c;
    for (int i = 0; i < NCH; i++) begin
      ml[i] = IW - 1; mr[i] = 0; mt[i] = (1 << CW) - 1; mb[i] = 0; mc[i] = 0;
    end
    for (int k = 0; k < hx.size(); k++) begin
      if (hy[k] * IW + hx[k] < n_pix && hy[k] >= ROI && hd[k] != '0) begin
        c = -1;
        for (int i = NCH - 1; i >= 0; i--) if (hd[k][i]) c = i;
        if (hx[k] < ml[c]) ml[c] = hx[k];
        if (hx[k] > mr[c]) mr[c] = hx[k];
        if (hy[k] < mt[c]) mt[c] = hy[k];
        if (hy[k] > mb[c]) mb[c] = hy[k];
        mc[c]++;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      e_left[i*CW +: CW]  = CW'(ml[i]);
      e_right[i*CW +: CW] = CW'(mr[i]);
      e_top[i*CW +: CW]   = CW'(mt[i]);
      e_bot[i*CW +: CW]   = CW'(mb[i]);
      e_valid[i]          = (mc[i] >= int'(min_pix));
    end
    if (fcnt == 0) begin
      fcnt = MI - 1;
      last_hdr = {16'h4242, 8'(NCH), 8'(seq)};
      exp_q.push_back(last_hdr);
      seq = (seq + 1) % 256;
      for (int i = 0; i < NCH; i++) begin
        exp_q.push_back({e_valid[i], 15'(ml[i]), 16'(mt[i])});
        exp_q.push_back({1'b0, 15'(mr[i]), 16'(mb[i])});
      end
      last_tl0 = {e_valid[0], 15'(ml[0]), 16'(mt[0])};
    end else begin
      fcnt--;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    e_left = '0; e_right = '0; e_top = '0; e_bot = '0; e_valid = '0;
    fcnt = 0; seq = 0; exp_done = 0; exp_drop = 0;
  endtask

  task automatic idle_drive();
    bus.pix_valid = 1'b0; bus.pix_sop = 1'b0; bus.pix_eop = 1'b0;
    bus.pix_is_video = 1'b0; bus.det = '1;
  endtask

  task automatic send_packet(input bit video, input int n_pix, input bit with_eop);
    bit busy = 0;
    bit last;
    @(posedge clk); #1;
    bus.pix_valid = 1'b1; bus.pix_sop = 1'b1; bus.pix_eop = 1'b0;
    bus.pix_is_video = video; bus.det = '1;
    for (int k = 0; k < n_pix; k++) begin
      if (k % 16 == 15) begin
        @(posedge clk); #1;
        idle_drive();
      end
      @(posedge clk); #1;
      last = with_eop && (k == n_pix - 1);
      if (last) busy = (exp_q.size() != 0);
      bus.pix_valid = 1'b1; bus.pix_sop = 1'b0; bus.pix_eop = last;
      bus.pix_is_video = 1'b0;
      bus.det = video ? det_at(k % IW, k / IW) : '1;
    end
    if (with_eop) begin
      @(posedge clk); #1;
      idle_drive();
      if (video) begin
        if (busy) exp_drop = 1;
        else begin
          exp_done = 1;
          model_latch(n_pix);
        end
      end
      @(posedge clk); #1;
      exp_done = 0; exp_drop = 0;
    end
  endtask

  task automatic wait_burst();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("burst_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic hits_a();
    clear_hits();
    for (int y = 30; y <= 33; y++)
      for (int x = 100; x <= 104; x++) add_hit(x, y, 5'b00001);
    add_hit(5, 10, 5'b00001);
    add_hit(10, 28, 5'b00110);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("msg_valid", bus.msg_valid, exp_q.size() != 0);
      check("frame_done", frame_done, exp_done);
      check("frame_drop", frame_drop, exp_drop);
      check("bb_outputs", {bb_left, bb_right, bb_top, bb_bot, bb_valid},
            {e_left, e_right, e_top, e_bot, e_valid});
      if (frame_done) dones_seen++;
      if (frame_drop) drops_seen++;
      if (reset_n && prev_stall) check("stall_hold", bus.msg_data, prev_data);
      if (reset_n && bus.msg_valid && bus.msg_ready && exp_q.size() != 0)
        check("msg_word", bus.msg_data, exp_q.pop_front());
      prev_stall = reset_n && bus.msg_valid && !bus.msg_ready;
      prev_data  = bus.msg_data;
    end
  end

  initial begin
    bus.msg_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) bus.msg_ready = ~bus.msg_ready;
      else bus.msg_ready = 1'b0;
    end
  end

  initial begin
    idle_drive();
    bus.det = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en = 1;
    @(negedge clk);
    check("rst_bb_left", bb_left, 0);
    check("rst_bb_top", bb_top, 0);
    check("rst_bb_valid", bb_valid, 0);
    check("rst_msg_valid", bus.msg_valid, 0);
    check("rst_state", dbg_state, 0);
    rdy_mode = 1;

    // Frame A: ch0 block, ch0 hit above ROI, one two-channel pixel.
    hits_a();
    min_pix = 20'd16;
    send_packet(1, NPIX, 1);
    check("A_left0", bb_left[CW-1:0], 100);
    check("A_right0", bb_right[CW-1:0], 104);
    check("A_top0", bb_top[CW-1:0], 30);
    check("A_bot0", bb_bot[CW-1:0], 33);
    check("A_valid", bb_valid, 5'b00001);
    check("A_left1", bb_left[CW +: CW], 10);
    check("A_left2_empty", bb_left[2*CW +: CW], 119);
    check("A_right2_empty", bb_right[2*CW +: CW], 0);
    check("A_hdr_model", last_hdr, 32'h42420500);
    check("A_tl0_model", last_tl0, 32'h8064001E);
    check("A_done_count", dones_seen, 1);
    wait_burst();

    // Frame B: same content, threshold above the count.
    min_pix = 20'd21;
    send_packet(1, NPIX, 1);
    check("B_valid", bb_valid, 5'b00000);
    check("B_left0", bb_left[CW-1:0], 100);
    check("B_no_burst", bus.msg_valid, 0);

    // Non-video packet full of detections.
    clear_hits();
    send_packet(0, 500, 1);
    check("C_left0", bb_left[CW-1:0], 100);
    check("C_done_count", dones_seen, 2);

    // Frame D: ROI edge row, first/last column, EOP pixel hit; burst then stalls.
    clear_hits();
    add_hit(0, 24, 5'b01000);
    add_hit(119, 35, 5'b01000);
    add_hit(50, 30, 5'b11000);
    add_hit(60, 23, 5'b10000);
    add_hit(5, 25, 5'b10000);
    min_pix = 20'd1;
    rdy_mode = 0;
    send_packet(1, NPIX, 1);
    check("D_left3", bb_left[3*CW +: CW], 0);
    check("D_right3", bb_right[3*CW +: CW], 119);
    check("D_top3", bb_top[3*CW +: CW], 24);
    check("D_bot3", bb_bot[3*CW +: CW], 35);
    check("D_top4", bb_top[4*CW +: CW], 25);
    check("D_valid", bb_valid, 5'b11000);
    check("D_hdr_model", last_hdr, 32'h42420501);

    // Frame E arrives while the burst is stalled.
    clear_hits();
    add_hit(1, 30, 5'b00001);
    send_packet(1, NPIX, 1);
    check("E_drop_count", drops_seen, 1);
    check("E_left3_held", bb_left[3*CW +: CW], 0);
    rdy_mode = 1;
    wait_burst();

    // Frame F: aborted partial packet, then a complete one.
    clear_hits();
    add_hit(7, 24, 5'b00100);
    send_packet(1, 3000, 0);
    clear_hits();
    add_hit(9, 26, 5'b00100);
    send_packet(1, NPIX, 1);
    check("F_left2", bb_left[2*CW +: CW], 9);
    check("F_top2", bb_top[2*CW +: CW], 26);
    check("F_valid", bb_valid, 5'b00100);

    // Frame G: burst interrupted by reset.
    hits_a();
    min_pix = 20'd16;
    send_packet(1, NPIX, 1);
    check("G_hdr_model", last_hdr, 32'h42420502);
    for (int i = 0; i < 100 && exp_q.size() > 7; i++) @(posedge clk);
    #1;
    check("G_partial", exp_q.size() <= 7, 1);
    do_reset();
    @(negedge clk);
    check("G_abort_valid", bus.msg_valid, 0);
    check("G_abort_bb", bb_left, 0);
    repeat (5) @(posedge clk);
    #1;
    check("G_no_reissue", bus.msg_valid, 0);

    // Frame H: sequence restarts from zero after reset.
    send_packet(1, NPIX, 1);
    check("H_hdr_model", last_hdr, 32'h42420500);
    check("H_left0", bb_left[CW-1:0], 100);
    wait_burst();

    repeat (3) @(posedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
